// File: rtl/laser_tx_scheduler.sv
// Sequences byte-pair packets from the control and data requesters onto the dual-laser transmitter.
// Define LASER_SCHED_TIMEOUT_EN to add the LOAD stall timeout and the pkt_abort output.
//
// state | meaning
// IDLE  | no packet; requests arbitrated here
// LOAD  | grant held, tx_en high, waiting for the winner's next pair
// SEND  | pair handed to the transmitter, waiting for tx_done
// GAP   | tx_en low for GAP_CYCLES before requests are looked at again
module laser_tx_scheduler #(
  parameter int LEN_W        = 10,
  parameter int GAP_CYCLES   = 2,
  parameter int STARVE_LIMIT = 4
`ifdef LASER_SCHED_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctl_req,
  input  logic [LEN_W-1:0] ctl_len,
  input  logic             ctl_valid,
  input  logic [7:0]       ctl_data1,
  input  logic [7:0]       ctl_data2,
  output logic             ctl_grant,
  output logic             ctl_pop,
  input  logic             dat_req,
  input  logic [LEN_W-1:0] dat_len,
  input  logic             dat_valid,
  input  logic [7:0]       dat_data1,
  input  logic [7:0]       dat_data2,
  output logic             dat_grant,
  output logic             dat_pop,
  output logic             tx_en,
  output logic [7:0]       tx_data1,
  output logic [7:0]       tx_data2,
  output logic             tx_ready,
  input  logic             tx_done,
  output logic             pkt_done,
`ifdef LASER_SCHED_TIMEOUT_EN
  output logic             pkt_abort,
`endif
  output logic             pkt_src,
  output logic [LEN_W-1:0] tx_ct,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);
  localparam logic [GW-1:0] GAP_LOAD   = GW'(GAP_CYCLES - 1);

  state_t           state, state_n;
  logic [LEN_W-1:0] len_q, len_n, tx_ct_n;
  logic [SW-1:0]    streak, streak_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             src_n, ctl_grant_n, dat_grant_n, ctl_pop_n, dat_pop_n;
  logic             tx_en_n, tx_ready_n, pkt_done_n;
  logic [7:0]       tx_data1_n, tx_data2_n;
  logic             ctl_win, win_valid, end_pkt;

`ifdef LASER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] to_cnt, to_cnt_n;
  logic          pkt_abort_n;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_n     = state;
    len_n       = len_q;
    src_n       = pkt_src;
    ctl_grant_n = ctl_grant;
    dat_grant_n = dat_grant;
    ctl_pop_n   = 1'b0;
    dat_pop_n   = 1'b0;
    tx_en_n     = tx_en;
    tx_data1_n  = tx_data1;
    tx_data2_n  = tx_data2;
    tx_ready_n  = 1'b0;
    pkt_done_n  = 1'b0;
    tx_ct_n     = tx_ct;
    streak_n    = streak;
    gap_n       = gap_cnt;
    end_pkt     = 1'b0;
    ctl_win     = ctl_req && (!dat_req || (streak < STREAK_MAX));
    win_valid   = pkt_src ? ctl_valid : dat_valid;
`ifdef LASER_SCHED_TIMEOUT_EN
    to_cnt_n    = '0;
    pkt_abort_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (ctl_req || dat_req) begin
          state_n = LOAD;
          tx_en_n = 1'b1;
          tx_ct_n = '0;
          src_n   = ctl_win;
          if (ctl_win) begin
            ctl_grant_n = 1'b1;
            len_n       = ctl_len;
            if (dat_req && (streak != STREAK_MAX)) streak_n = streak + SW'(1);
          end else begin
            dat_grant_n = 1'b1;
            len_n       = dat_len;
            streak_n    = '0;
          end
        end
      end
      LOAD: begin
        if (len_q == '0) begin
          end_pkt    = 1'b1;
          pkt_done_n = 1'b1;
        end
`ifdef LASER_SCHED_TIMEOUT_EN
        else if (pkt_abort) begin
          end_pkt = 1'b1;
        end
`endif
        else if (win_valid) begin
          state_n    = SEND;
          tx_data1_n = pkt_src ? ctl_data1 : dat_data1;
          tx_data2_n = pkt_src ? ctl_data2 : dat_data2;
          ctl_pop_n  = pkt_src;
          dat_pop_n  = !pkt_src;
          tx_ready_n = 1'b1;
        end
`ifdef LASER_SCHED_TIMEOUT_EN
        else begin
          // abort is flagged during the last allowed stall cycle and taken on the next edge
          to_cnt_n = to_cnt + TW'(1);
          if (to_cnt_n == TO_LAST) pkt_abort_n = 1'b1;
        end
`endif
      end
      SEND: begin
        if (tx_done) begin
          tx_ct_n = tx_ct + LEN_W'(1);
          if (tx_ct_n == len_q) begin
            end_pkt    = 1'b1;
            pkt_done_n = 1'b1;
          end else begin
            state_n = LOAD;
          end
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_n = IDLE;
        else               gap_n   = gap_cnt - GW'(1);
      end
      default: state_n = IDLE;
    endcase
    if (end_pkt) begin
      state_n     = GAP;
      gap_n       = GAP_LOAD;
      ctl_grant_n = 1'b0;
      dat_grant_n = 1'b0;
      tx_en_n     = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      len_q     <= '0;
      pkt_src   <= 1'b0;
      ctl_grant <= 1'b0;
      dat_grant <= 1'b0;
      ctl_pop   <= 1'b0;
      dat_pop   <= 1'b0;
      tx_en     <= 1'b0;
      tx_data1  <= '0;
      tx_data2  <= '0;
      tx_ready  <= 1'b0;
      pkt_done  <= 1'b0;
      tx_ct     <= '0;
      streak    <= '0;
      gap_cnt   <= '0;
`ifdef LASER_SCHED_TIMEOUT_EN
      to_cnt    <= '0;
      pkt_abort <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      pkt_src   <= src_n;
      ctl_grant <= ctl_grant_n;
      dat_grant <= dat_grant_n;
      ctl_pop   <= ctl_pop_n;
      dat_pop   <= dat_pop_n;
      tx_en     <= tx_en_n;
      tx_data1  <= tx_data1_n;
      tx_data2  <= tx_data2_n;
      tx_ready  <= tx_ready_n;
      pkt_done  <= pkt_done_n;
      tx_ct     <= tx_ct_n;
      streak    <= streak_n;
      gap_cnt   <= gap_n;
`ifdef LASER_SCHED_TIMEOUT_EN
      to_cnt    <= to_cnt_n;
      pkt_abort <= pkt_abort_n;
`endif
    end
  end

endmodule

// File: tb/tb_laser_tx_scheduler.sv
// Bench for laser_tx_scheduler: requester/transmitter emulation plus a packet-level reference model.
module tb_laser_tx_scheduler;
  localparam int LEN_W = 10;
  localparam int GAP_CYCLES = 2;
  localparam int STARVE_LIMIT = 4;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic ctl_req, ctl_valid, dat_req, dat_valid, tx_done;
  logic [LEN_W-1:0] ctl_len, dat_len;
  logic [7:0] ctl_data1, ctl_data2, dat_data1, dat_data2;
  logic ctl_grant, ctl_pop, dat_grant, dat_pop, tx_en, tx_ready, pkt_done, pkt_src, busy;
  logic [7:0] tx_data1, tx_data2;
  logic [LEN_W-1:0] tx_ct;
`ifdef LASER_SCHED_TIMEOUT_EN
  logic pkt_abort;
`endif

  always #5 clock = ~clock;

  laser_tx_scheduler #(.LEN_W(LEN_W), .GAP_CYCLES(GAP_CYCLES), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock(clock), .reset(reset),
    .ctl_req(ctl_req), .ctl_len(ctl_len), .ctl_valid(ctl_valid),
    .ctl_data1(ctl_data1), .ctl_data2(ctl_data2), .ctl_grant(ctl_grant), .ctl_pop(ctl_pop),
    .dat_req(dat_req), .dat_len(dat_len), .dat_valid(dat_valid),
    .dat_data1(dat_data1), .dat_data2(dat_data2), .dat_grant(dat_grant), .dat_pop(dat_pop),
    .tx_en(tx_en), .tx_data1(tx_data1), .tx_data2(tx_data2), .tx_ready(tx_ready),
    .tx_done(tx_done), .pkt_done(pkt_done),
`ifdef LASER_SCHED_TIMEOUT_EN
    .pkt_abort(pkt_abort),
`endif
    .pkt_src(pkt_src), .tx_ct(tx_ct), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [7:0] c1[1024], c2[1024], d1[1024], d2[1024];
  int ctl_idx = 0, dat_idx = 0;
  int ctl_pkts[$], dat_pkts[$];
  int vpct, lat, dw, hold_idx, hold_left, stall_bad;
  bit spur, holding;

  bit grant_q[$], done_src_q[$];
  int done_ct_q[$], gap_q[$], ct_q[$];
  logic [16:0] pair_q[$];
  int n_pop, n_ready, viol, gap_run, g_cyc, d_cyc;
  int abort_n, abort_cyc;
  bit prev_abort, post_abort_grant;
  logic prev_cg, prev_dg;
  logic [LEN_W-1:0] prev_ct;

  bit exp_src_q[$];
  int exp_len_q[$];
  logic [16:0] exp_pair_q[$];

  task automatic clear_logs();
    grant_q.delete(); done_src_q.delete(); done_ct_q.delete();
    gap_q.delete(); ct_q.delete(); pair_q.delete();
    n_pop = 0; n_ready = 0; viol = 0; gap_run = 0; g_cyc = 0; d_cyc = 0;
    abort_n = 0; abort_cyc = 0; prev_abort = 0; post_abort_grant = 0;
    prev_cg = 1'b0; prev_dg = 1'b0; prev_ct = '0; stall_bad = 0;
  endtask

  task automatic drive_inputs();
    ctl_req   = (ctl_pkts.size() != 0);
    ctl_len   = (ctl_pkts.size() != 0) ? LEN_W'(ctl_pkts[0]) : '0;
    dat_req   = (dat_pkts.size() != 0);
    dat_len   = (dat_pkts.size() != 0) ? LEN_W'(dat_pkts[0]) : '0;
    ctl_data1 = c1[ctl_idx % 1024];
    ctl_data2 = c2[ctl_idx % 1024];
    dat_data1 = d1[dat_idx % 1024];
    dat_data2 = d2[dat_idx % 1024];
    ctl_valid = ($urandom_range(0, 99) < vpct);
    dat_valid = ($urandom_range(0, 99) < vpct);
    holding   = (dat_idx == hold_idx) && (hold_left > 0);
    if (holding) begin
      dat_valid = 1'b0;
      hold_left--;
    end
  endtask

  // One clock: observe the DUT, emulate requesters and transmitter, drive the next inputs.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    if (holding && (!tx_en || tx_ready)) stall_bad++;
    if (tx_ready) begin
      n_ready++;
      pair_q.push_back({pkt_src, tx_data1, tx_data2});
      if (!tx_en) viol++;
    end
    if ((ctl_pop || dat_pop) != tx_ready) viol++;
    if ((ctl_pop && !ctl_grant) || (dat_pop && !dat_grant) || (ctl_grant && dat_grant)) viol++;
    if (pkt_done && (ctl_grant || dat_grant)) viol++;
    if (ctl_pop) begin n_pop++; ctl_idx++; end
    if (dat_pop) begin n_pop++; dat_idx++; end
    if (ctl_grant && !prev_cg) begin
      grant_q.push_back(1'b1); g_cyc = cyc;
      if (ctl_pkts.size() != 0) void'(ctl_pkts.pop_front());
    end
    if (dat_grant && !prev_dg) begin
      grant_q.push_back(1'b0); g_cyc = cyc;
      if (dat_pkts.size() != 0) void'(dat_pkts.pop_front());
    end
    prev_cg = ctl_grant;
    prev_dg = dat_grant;
    if (pkt_done) begin
      done_src_q.push_back(pkt_src);
      done_ct_q.push_back(int'(tx_ct));
      d_cyc = cyc;
    end
    if (tx_ct != prev_ct && tx_ct != '0) ct_q.push_back(int'(tx_ct));
    prev_ct = tx_ct;
    if (busy && !tx_en) gap_run++;
    else if (gap_run != 0) begin gap_q.push_back(gap_run); gap_run = 0; end
`ifdef LASER_SCHED_TIMEOUT_EN
    if (prev_abort) post_abort_grant = ctl_grant || dat_grant;
    prev_abort = pkt_abort;
    if (pkt_abort) begin abort_n++; abort_cyc = cyc; end
`endif
    tx_done = 1'b0;
    if (tx_ready) dw = lat;
    else if (dw > 0) begin
      dw--;
      if (dw == 0) tx_done = 1'b1;
    end
    if (!tx_done && dw == 0 && !tx_en && spur && $urandom_range(0, 3) == 0) tx_done = 1'b1;
    drive_inputs();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    ctl_pkts.delete(); dat_pkts.delete();
    vpct = 100; lat = 4; dw = 0; hold_idx = -1; hold_left = 0; spur = 0;
    tx_done = 1'b0;
    drive_inputs();
    step(); step();
    reset = 1'b1;
    clear_logs();
  endtask

  task automatic run_idle(input int max, output bit to);
    int n = 0;
    to = 0;
    step();
    while (ctl_pkts.size() != 0 || dat_pkts.size() != 0 || busy || dw != 0) begin
      if (n == max) begin to = 1; break; end
      step();
      n++;
    end
  endtask

  // Packet-level model: grant order from the starvation rule, then each packet's pairs in order.
  task automatic build_model();
    int cq[$] = ctl_pkts;
    int dq[$] = dat_pkts;
    int s = 0, ci = ctl_idx, di = dat_idx, len;
    exp_src_q.delete(); exp_len_q.delete(); exp_pair_q.delete();
    while (cq.size() != 0 || dq.size() != 0) begin
      if (cq.size() != 0 && (dq.size() == 0 || s < STARVE_LIMIT)) begin
        len = cq.pop_front();
        if (dq.size() != 0 && s < STARVE_LIMIT) s++;
        exp_src_q.push_back(1'b1);
        exp_len_q.push_back(len);
        for (int k = 0; k < len; k++) begin
          exp_pair_q.push_back({1'b1, c1[ci % 1024], c2[ci % 1024]});
          ci++;
        end
      end else begin
        len = dq.pop_front();
        s = 0;
        exp_src_q.push_back(1'b0);
        exp_len_q.push_back(len);
        for (int k = 0; k < len; k++) begin
          exp_pair_q.push_back({1'b0, d1[di % 1024], d2[di % 1024]});
          di++;
        end
      end
    end
  endtask

  task automatic test_reset();
    logic [32:0] outs;
    reset = 1'b0;
    ctl_pkts = '{1}; dat_pkts = '{2};
    vpct = 0; lat = 4; dw = 0; hold_idx = -1; hold_left = 0; spur = 0; tx_done = 1'b0;
    clear_logs();
    drive_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      outs = {ctl_grant, ctl_pop, dat_grant, dat_pop, tx_en, tx_data1, tx_data2,
              tx_ready, pkt_done, pkt_src, tx_ct, busy};
      checks++;
      if (outs !== '0) $display("FAIL reset_outputs cycle=%0d got=%h exp=0", i, outs);
      if (outs !== '0) failures++;
    end
    reset = 1'b1;
    step();
    checks++;
    if ({ctl_grant, dat_grant, tx_en, pkt_src} !== 4'b1011) begin
      $display("FAIL grant_after_reset got=%b exp=1011", {ctl_grant, dat_grant, tx_en, pkt_src});
      failures++;
    end
    dat_pkts.delete();
    reset = 1'b0;
    step();
    reset = 1'b1;
    checks++;
    if ({ctl_grant, tx_en, busy} !== 3'b000) begin
      $display("FAIL midpkt_reset got=%b exp=000", {ctl_grant, tx_en, busy});
      failures++;
    end
    step(); step(); step();
    checks++;
    if (n_pop != 0 || done_src_q.size() != 0 || busy !== 1'b0) begin
      $display("FAIL abandon_pkt pops=%0d dones=%0d busy=%b exp=0,0,0", n_pop, done_src_q.size(), busy);
      failures++;
    end
  endtask

  task automatic test_ctl_packet();
    bit to;
    apply_reset();
    ctl_pkts = '{4}; lat = 11;
    build_model();
    drive_inputs();
    run_idle(2000, to);
    checks++;
    if (to) begin $display("FAIL ctl_pkt_timeout got=1 exp=0"); failures++; end
    checks++;
    if (n_pop != 4 || n_ready != 4) begin
      $display("FAIL ctl_pkt_pops pops=%0d ready=%0d exp=4,4", n_pop, n_ready); failures++;
    end
    checks++;
    if (ct_q.size() != 4) begin $display("FAIL ctl_pkt_ct_len got=%0d exp=4", ct_q.size()); failures++; end
    for (int i = 0; i < ct_q.size() && i < 4; i++) begin
      checks++;
      if (ct_q[i] != i + 1) begin $display("FAIL ctl_pkt_ct[%0d] got=%0d exp=%0d", i, ct_q[i], i + 1); failures++; end
    end
    checks++;
    if (done_ct_q.size() != 1 || tx_ct !== LEN_W'(4)) begin
      $display("FAIL ctl_pkt_done dones=%0d tx_ct=%0d exp=1,4", done_ct_q.size(), tx_ct); failures++;
    end
    checks++;
    if (gap_q.size() != 1 || (gap_q.size() == 1 && gap_q[0] != GAP_CYCLES)) begin
      $display("FAIL ctl_pkt_gap runs=%0d first=%0d exp=1,%0d", gap_q.size(),
               (gap_q.size() != 0) ? gap_q[0] : -1, GAP_CYCLES); failures++;
    end
    for (int i = 0; i < exp_pair_q.size(); i++) begin
      checks++;
      if (i >= pair_q.size() || pair_q[i] !== exp_pair_q[i]) begin
        $display("FAIL ctl_pkt_pair[%0d] got=%h exp=%h", i, (i < pair_q.size()) ? pair_q[i] : 17'h0, exp_pair_q[i]);
        failures++;
      end
    end
    checks++;
    if (viol != 0 || busy !== 1'b0 || pkt_src !== 1'b1) begin
      $display("FAIL ctl_pkt_end viol=%0d busy=%b src=%b exp=0,0,1", viol, busy, pkt_src); failures++;
    end
  endtask

  task automatic test_starvation();
    bit to;
    bit pat[8] = '{1, 1, 1, 1, 0, 1, 1, 0};
    apply_reset();
    ctl_pkts = '{2, 2, 2, 2, 2, 2}; dat_pkts = '{2, 2}; lat = 2;
    build_model();
    drive_inputs();
    run_idle(3000, to);
    checks++;
    if (to || grant_q.size() != 8) begin
      $display("FAIL starve_grants timeout=%0d grants=%0d exp=0,8", to, grant_q.size()); failures++;
    end
    for (int i = 0; i < 8 && i < grant_q.size(); i++) begin
      checks++;
      if (grant_q[i] != pat[i]) begin $display("FAIL starve_order[%0d] got=%0d exp=%0d", i, grant_q[i], pat[i]); failures++; end
    end
    checks++;
    if (pair_q.size() != exp_pair_q.size() || viol != 0) begin
      $display("FAIL starve_pairs got=%0d exp=%0d viol=%0d", pair_q.size(), exp_pair_q.size(), viol); failures++;
    end
  endtask

  task automatic test_stall();
    bit to;
    apply_reset();
    dat_pkts = '{3}; lat = 3;
    hold_idx = dat_idx + 1; hold_left = 20;
    build_model();
    drive_inputs();
    run_idle(2000, to);
    checks++;
    if (to || hold_left != 0) begin $display("FAIL stall_run timeout=%0d hold_left=%0d exp=0,0", to, hold_left); failures++; end
    checks++;
    if (stall_bad != 0) begin $display("FAIL stall_tx_en_ready got=%0d exp=0", stall_bad); failures++; end
    checks++;
    if (tx_ct !== LEN_W'(3) || done_ct_q.size() != 1 || n_ready != 3) begin
      $display("FAIL stall_done tx_ct=%0d dones=%0d ready=%0d exp=3,1,3", tx_ct, done_ct_q.size(), n_ready); failures++;
    end
    for (int i = 0; i < exp_pair_q.size(); i++) begin
      checks++;
      if (i >= pair_q.size() || pair_q[i] !== exp_pair_q[i]) begin
        $display("FAIL stall_pair[%0d] got=%h exp=%h", i, (i < pair_q.size()) ? pair_q[i] : 17'h0, exp_pair_q[i]);
        failures++;
      end
    end
  endtask

  task automatic test_zero_len();
    bit to;
    apply_reset();
    ctl_pkts = '{0};
    drive_inputs();
    run_idle(500, to);
    checks++;
    if (to || done_ct_q.size() != 1 || (d_cyc - g_cyc) != 1) begin
      $display("FAIL zero_len_done timeout=%0d dones=%0d latency=%0d exp=0,1,1", to, done_ct_q.size(), d_cyc - g_cyc);
      failures++;
    end
    checks++;
    if (n_pop != 0 || n_ready != 0 || tx_ct !== '0) begin
      $display("FAIL zero_len_nopop pops=%0d ready=%0d tx_ct=%0d exp=0,0,0", n_pop, n_ready, tx_ct); failures++;
    end
    checks++;
    if (gap_q.size() != 1 || (gap_q.size() == 1 && gap_q[0] != GAP_CYCLES)) begin
      $display("FAIL zero_len_gap runs=%0d exp=1 len=%0d", gap_q.size(), GAP_CYCLES); failures++;
    end
  endtask

  task automatic test_random();
    bit to;
    int npk, npairs;
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      npairs = 0;
      for (int i = $urandom_range(2, 6); i > 0; i--) ctl_pkts.push_back(int'($urandom_range(0, 5)));
      for (int i = $urandom_range(2, 6); i > 0; i--) dat_pkts.push_back(int'($urandom_range(0, 5)));
      vpct = $urandom_range(30, 100); lat = $urandom_range(1, 6); spur = 1;
      build_model();
      npk = exp_src_q.size();
      foreach (exp_len_q[i]) npairs += exp_len_q[i];
      drive_inputs();
      run_idle(20000, to);
      checks++;
      if (to || viol != 0) begin $display("FAIL rand%0d_run timeout=%0d viol=%0d exp=0,0", r, to, viol); failures++; end
      checks++;
      if (grant_q.size() != npk || done_src_q.size() != npk || n_pop != npairs) begin
        $display("FAIL rand%0d_counts grants=%0d dones=%0d pops=%0d exp=%0d,%0d,%0d", r,
                 grant_q.size(), done_src_q.size(), n_pop, npk, npk, npairs);
        failures++;
      end
      for (int i = 0; i < npk && i < grant_q.size() && i < done_src_q.size(); i++) begin
        checks++;
        if (grant_q[i] != exp_src_q[i] || done_src_q[i] != exp_src_q[i] || done_ct_q[i] != exp_len_q[i]) begin
          $display("FAIL rand%0d_pkt[%0d] grant=%0d src=%0d ct=%0d exp=%0d,%0d,%0d", r, i, grant_q[i],
                   done_src_q[i], done_ct_q[i], exp_src_q[i], exp_src_q[i], exp_len_q[i]);
          failures++;
        end
      end
      for (int i = 0; i < npairs; i++) begin
        checks++;
        if (i >= pair_q.size() || pair_q[i] !== exp_pair_q[i]) begin
          $display("FAIL rand%0d_pair[%0d] got=%h exp=%h", r, i, (i < pair_q.size()) ? pair_q[i] : 17'h0, exp_pair_q[i]);
          failures++;
        end
      end
      checks++;
      if (gap_q.size() != npk) begin $display("FAIL rand%0d_gaps got=%0d exp=%0d", r, gap_q.size(), npk); failures++; end
      foreach (gap_q[i]) begin
        checks++;
        if (gap_q[i] != GAP_CYCLES) begin $display("FAIL rand%0d_gap[%0d] got=%0d exp=%0d", r, i, gap_q[i], GAP_CYCLES); failures++; end
      end
    end
  endtask

`ifdef LASER_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit to;
    apply_reset();
    dat_pkts = '{2}; vpct = 0;
    drive_inputs();
    run_idle(1000, to);
    checks++;
    if (to || abort_n != 1 || (abort_cyc - g_cyc) != 63) begin
      $display("FAIL timeout_abort timeout=%0d aborts=%0d at=%0d exp=0,1,63", to, abort_n, abort_cyc - g_cyc);
      failures++;
    end
    checks++;
    if (post_abort_grant || done_src_q.size() != 0 || n_pop != 0) begin
      $display("FAIL timeout_after grant=%0d dones=%0d pops=%0d exp=0,0,0", post_abort_grant, done_src_q.size(), n_pop);
      failures++;
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 1024; i++) begin
      c1[i] = 8'($urandom); c2[i] = 8'($urandom);
      d1[i] = 8'($urandom); d2[i] = 8'($urandom);
    end
    test_reset();
    test_ctl_packet();
    test_starvation();
    test_stall();
    test_zero_len();
    test_random();
`ifdef LASER_SCHED_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
